// File: rtl/fir_out_buffer.sv
`default_nettype none
// ============================================================================
// Module   : fir_out_buffer
// Purpose  : Output stage for a FIR filter. Requantises each 16-bit filter
//            sample (arithmetic right shift by SHIFT, optional round-half-up,
//            clamp to OUT_W signed bits), discards the first WARMUP samples
//            after reset while the filter pipeline fills, and buffers the
//            results in a DEPTH-entry FIFO behind a valid/ready interface.
// Config   : define FIR_OUT_ROUND_EN to add 2^(SHIFT-1) before the shift
//            (round-half-up); leave undefined for truncation (floor).
// Ports    : clk      - rising-edge clock
//            rst      - asynchronous active-high reset
//            en       - yn is valid this cycle
//            yn       - signed FIR output sample (16 bit)
//            m_data   - signed requantised FIFO head (0 when m_valid=0)
//            m_valid  - FIFO not empty
//            m_ready  - downstream accepts m_data this cycle
//            fill     - FIFO occupancy (0..DEPTH)
//            ovf_cnt  - samples dropped on full, saturates at 16'hFFFF
//            sat_flag - sticky: a stored sample was clamped
//            sat_clr  - synchronous clear of sat_flag (a same-cycle set wins)
// Revision : 1.0 - initial release
// ============================================================================
module fir_out_buffer #(
   parameter int DEPTH  = 8,
   parameter int SHIFT  = 2,
   parameter int OUT_W  = 12,
   parameter int WARMUP = 17
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic signed [15:0]         yn,
   output logic signed [OUT_W-1:0]    m_data,
   output logic                       m_valid,
   input  logic                       m_ready,
   output logic [$clog2(DEPTH):0]     fill,
   output logic [15:0]                ovf_cnt,
   output logic                       sat_flag,
   input  logic                       sat_clr
);

   localparam int AW = $clog2(DEPTH);

`ifdef FIR_OUT_ROUND_EN
   // The inner conditional keeps the shift amount non-negative when SHIFT=0.
   localparam int RND = (SHIFT > 0) ? (1 << ((SHIFT > 0) ? (SHIFT - 1) : 0)) : 0;
`else
   localparam int RND = 0;
`endif

   localparam logic signed [16:0] RND17 = 17'(RND);
   localparam logic signed [16:0] QMAX  = 17'((1 << (OUT_W - 1)) - 1);
   localparam logic signed [16:0] QMIN  = 17'(-(1 << (OUT_W - 1)));
   localparam logic [AW:0]        FILL_ONE  = (AW + 1)'(1);
   localparam logic [AW:0]        FILL_FULL = (AW + 1)'(DEPTH);
   localparam logic [AW-1:0]      PTR_ONE   = AW'(1);
   localparam logic [7:0]         LAST_DISCARD = 8'(WARMUP - 1);

   typedef enum logic [0:0] {
      ST_WARMUP = 1'b0,
      ST_RUN    = 1'b1
   } state_t;

   localparam state_t START_STATE = (WARMUP == 0) ? ST_RUN : ST_WARMUP;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   state_t                    state_q;
   logic [7:0]                discard_q;
   logic [AW-1:0]             wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]             rd_ptr_q, rd_ptr_d;
   logic [AW:0]               fill_q, fill_d;
   logic [15:0]               ovf_q, ovf_d;
   logic                      sat_q, sat_d;
   logic signed [OUT_W-1:0]   mem_q [DEPTH];

   // ------------------------------------------------------------------------
   // Requantisation
   // ------------------------------------------------------------------------
   logic signed [16:0]        w_sum;
   logic signed [16:0]        w_shift;
   logic                      w_over;
   logic                      w_under;
   logic signed [OUT_W-1:0]   w_qval;

   always_comb begin
      // 17 bits hold yn plus the rounding constant without wrapping.
      w_sum   = {yn[15], yn} + RND17;
      w_shift = w_sum >>> SHIFT;
      w_over  = (w_shift > QMAX);
      w_under = (w_shift < QMIN);
      if (w_over) begin
         w_qval = QMAX[OUT_W-1:0];
      end else if (w_under) begin
         w_qval = QMIN[OUT_W-1:0];
      end else begin
         w_qval = w_shift[OUT_W-1:0];
      end
   end

   // ------------------------------------------------------------------------
   // FIFO control
   // ------------------------------------------------------------------------
   logic w_valid;
   logic w_full;
   logic w_wr_req;
   logic w_pop;
   logic w_push;
   logic w_drop;

   always_comb begin
      w_valid  = (fill_q != '0);
      w_full   = (fill_q == FILL_FULL);
      w_wr_req = (state_q == ST_RUN) && en;
      // Pop only when data was already present; an empty FIFO ignores m_ready.
      w_pop    = w_valid && m_ready;
      // A full FIFO still accepts a write when the head leaves the same cycle.
      w_push   = w_wr_req && (!w_full || w_pop);
      w_drop   = w_wr_req && w_full && !w_pop;
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      fill_d   = fill_q;
      ovf_d    = ovf_q;
      sat_d    = sat_q;

      // Pointers wrap naturally because DEPTH is a power of two.
      if (w_push) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (w_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end

      if (w_push && !w_pop) begin
         fill_d = fill_q + FILL_ONE;
      end else if (!w_push && w_pop) begin
         fill_d = fill_q - FILL_ONE;
      end

      if (w_drop && (ovf_q != 16'hFFFF)) begin
         ovf_d = ovf_q + 16'd1;
      end

      // Set has priority over clear so a clamp is never lost.
      if (w_push && (w_over || w_under)) begin
         sat_d = 1'b1;
      end else if (sat_clr) begin
         sat_d = 1'b0;
      end
   end

   // ------------------------------------------------------------------------
   // Warm-up / run state machine
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= START_STATE;
         discard_q <= 8'd0;
      end else begin
         case (state_q)
            ST_WARMUP: begin
               if (en) begin
                  discard_q <= discard_q + 8'd1;
                  // The WARMUP-th sample is still discarded; RUN starts after it.
                  if (discard_q == LAST_DISCARD) begin
                     state_q <= ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               state_q <= ST_RUN;
            end
            default: begin
               state_q <= START_STATE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // FIFO registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         fill_q   <= '0;
         ovf_q    <= 16'd0;
         sat_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         fill_q   <= fill_d;
         ovf_q    <= ovf_d;
         sat_q    <= sat_d;
      end
   end

   // Storage needs no reset: contents are only visible while fill is non-zero.
   always_ff @(posedge clk) begin
      if (w_push) begin
         mem_q[wr_ptr_q] <= w_qval;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign m_valid  = w_valid;
   assign m_data   = w_valid ? mem_q[rd_ptr_q] : '0;
   assign fill     = fill_q;
   assign ovf_cnt  = ovf_q;
   assign sat_flag = sat_q;

endmodule
`default_nettype wire
